// File: rtl/operand_fetch.sv
// In-order operand fetch: queues dispatched {src1, src2, dst}, reads both sources from the
// register file for the head entry, then holds the result until issue. Option: OPF_CDB_BYPASS_EN.
module operand_fetch #(
  parameter int PRF_SIZE = 16,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_src1,
  input  logic [3:0]          in_src2,
  input  logic [3:0]          in_dst,
  input  logic [PRF_SIZE-1:0] ready_regs,
  output logic                requesting,
  output logic [3:0]          requested_id,
  input  logic                prf_cdb_transmit,
  input  logic [3:0]          prf_cdb_id,
  input  logic [7:0]          prf_cdb_val,
  input  logic                shared_cdb_transmit,
  input  logic [3:0]          shared_cdb_id,
  input  logic [7:0]          shared_cdb_val,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_dst,
  output logic [7:0]          out_val1,
  output logic [7:0]          out_val2
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SRC1, S_SRC2, S_OUT} state_t;

  typedef struct packed {
    logic [3:0] src1;
    logic [3:0] src2;
    logic [3:0] dst;
  } entry_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [7:0]    val1_q, val1_d;
  logic [7:0]    val2_q, val2_d;

  entry_t     head;
  logic       push, pop, fetching, src_ready, snoop_hit, prf_hit, capture;
  logic [3:0] cur_src;
  logic [7:0] cap_val;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    in_ready  = (count_q < CW'(DEPTH));
    push      = in_valid && in_ready;
    out_valid = (state_q == S_OUT);
    pop       = out_valid && out_ready;
    fetching  = (state_q == S_SRC1) || (state_q == S_SRC2);
    cur_src   = (state_q == S_SRC2) ? head.src2 : head.src1;
    src_ready = ready_regs[cur_src];
  end

`ifdef OPF_CDB_BYPASS_EN
  // A matching broadcast wins over the register file and suppresses the read request.
  always_comb begin
    snoop_hit = fetching && shared_cdb_transmit && (shared_cdb_id == cur_src);
    cap_val   = snoop_hit ? shared_cdb_val : prf_cdb_val;
  end
`else
  logic unused_shared;
  always_comb begin
    snoop_hit     = 1'b0;
    cap_val       = prf_cdb_val;
    unused_shared = ^{shared_cdb_transmit, shared_cdb_id, shared_cdb_val};
  end
`endif

  always_comb begin
    requesting   = fetching && src_ready && !snoop_hit;
    requested_id = fetching ? cur_src : 4'd0;
    prf_hit      = requesting && prf_cdb_transmit && (prf_cdb_id == cur_src);
    capture      = snoop_hit || prf_hit;
    out_dst      = out_valid ? head.dst : 4'd0;
    out_val1     = out_valid ? val1_q : 8'd0;
    out_val2     = out_valid ? val2_q : 8'd0;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{src1: in_src1, src2: in_src2, dst: in_dst};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    val1_d  = val1_q;
    val2_d  = val2_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = S_SRC1;
      end
      S_SRC1: begin
        if (capture) begin
          val1_d = cap_val;
          if (head.src2 == head.src1) begin
            val2_d  = cap_val;
            state_d = S_OUT;
          end else begin
            state_d = S_SRC2;
          end
        end
      end
      S_SRC2: begin
        if (capture) begin
          val2_d  = cap_val;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (pop) state_d = (count_d != '0) ? S_SRC1 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      val1_q   <= '0;
      val2_q   <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      val1_q   <= val1_d;
      val2_q   <= val2_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch: expected {dst, val1, val2} queued at push, compared on issue.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_src1, in_src2, in_dst;
  logic [15:0] ready_regs;
  logic        requesting;
  logic [3:0]  requested_id;
  logic        prf_cdb_transmit;
  logic [3:0]  prf_cdb_id;
  logic [7:0]  prf_cdb_val;
  logic        shared_cdb_transmit;
  logic [3:0]  shared_cdb_id;
  logic [7:0]  shared_cdb_val;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_dst;
  logic [7:0]  out_val1, out_val2;

  always #5 clk = ~clk;

  operand_fetch #(.PRF_SIZE(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_dst(in_dst),
    .ready_regs(ready_regs),
    .requesting(requesting), .requested_id(requested_id),
    .prf_cdb_transmit(prf_cdb_transmit), .prf_cdb_id(prf_cdb_id), .prf_cdb_val(prf_cdb_val),
    .shared_cdb_transmit(shared_cdb_transmit), .shared_cdb_id(shared_cdb_id),
    .shared_cdb_val(shared_cdb_val),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dst(out_dst), .out_val1(out_val1), .out_val2(out_val2)
  );

  // Register-file model: answers a request in the same cycle; prf_bad corrupts the id.
  logic [7:0] regval [16];
  logic       prf_bad = 1'b0;
  assign prf_cdb_transmit = requesting;
  assign prf_cdb_id       = requested_id ^ {3'b000, prf_bad};
  assign prf_cdb_val      = regval[requested_id];

  typedef struct {
    logic [3:0] dst;
    logic [7:0] v1;
    logic [7:0] v2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   req_cnt = 0;
  logic [3:0] last_req_id = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    if (!rst && requesting) begin
      req_cnt++;
      last_req_id = requested_id;
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got dst=%0h val1=%0h val2=%0h expected none",
                 out_dst, out_val1, out_val2);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_dst", out_dst, mon_e.dst);
        check("out_val1", out_val1, mon_e.v1);
        check("out_val2", out_val2, mon_e.v2);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", in_ready, 1);
    end else begin
      in_src1  = s1;
      in_src2  = s2;
      in_dst   = d;
      in_valid = 1'b1;
      exp_q.push_back('{d, regval[s1], regval[s2]});
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_empty(input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    tick();
  endtask

  task automatic wait_req_id(input logic [3:0] id, input string name);
    int n = 0;
    while (requested_id != id && n < 30) begin
      tick();
      n++;
    end
    check(name, requested_id, id);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   lat;
    logic seen;
    logic [3:0] s1, s2;

    rst = 1'b1; in_valid = 1'b0; in_src1 = '0; in_src2 = '0; in_dst = '0;
    ready_regs = 16'hFFFF; out_ready = 1'b1;
    shared_cdb_transmit = 1'b0; shared_cdb_id = '0; shared_cdb_val = '0;
    for (int i = 0; i < 16; i++) regval[i] = 8'($urandom);

    // Reset state
    repeat (3) tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_requesting", requesting, 0);
    check("rst_requested_id", requested_id, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_vals", {out_dst, out_val1, out_val2}, 0);
    rst = 1'b0;
    tick();

    // Basic fetch and minimum latency
    regval[3] = 8'h11; regval[5] = 8'h22;
    push(4'd3, 4'd5, 4'd9);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency_edges", lat, 3);
    check("basic_out_dst", out_dst, 9);
    wait_empty(20);

    // Same source twice: one request only
    regval[7] = 8'h5A;
    req_cnt = 0;
    push(4'd7, 4'd7, 4'd2);
    wait_empty(20);
    check("same_src_req_cnt", req_cnt, 1);
    check("same_src_req_id", last_req_id, 7);

    // Source not ready: hold indefinitely, then fetch immediately
    ready_regs[4] = 1'b0;
    push(4'd4, 4'd1, 4'd6);
    seen = 1'b0;
    repeat (10) begin
      tick();
      if (requesting || out_valid) seen = 1'b1;
    end
    check("not_ready_hold", seen, 0);
    ready_regs[4] = 1'b1;
    #1;
    check("req_after_ready", requesting, 1);
    check("req_after_ready_id", requested_id, 4);
    tick();
    check("captured_src1", requested_id, 1);
    wait_empty(20);

    // Mismatched response id: no capture, retried
    prf_bad = 1'b1;
    push(4'd8, 4'd9, 4'd3);
    repeat (6) tick();
    check("mismatch_no_out", out_valid, 0);
    check("mismatch_retry", requesting, 1);
    check("mismatch_hold_id", requested_id, 8);
    prf_bad = 1'b0;
    wait_empty(20);

    // Fill, then drain in order with pointer wrap
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(4'($urandom), 4'($urandom), 4'(i));
    check("full_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) push(4'($urandom), 4'($urandom), 4'(i + 4));
    wait_empty(100);

    // Random traffic; snoop values agree with the register file so results are unaffected
    for (int c = 0; c < 400; c++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_src1    = 4'($urandom);
      in_src2    = 4'($urandom);
      in_dst     = 4'($urandom);
      ready_regs = 16'($urandom) | 16'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      shared_cdb_transmit = ($urandom_range(0, 3) == 0);
      shared_cdb_id  = 4'($urandom);
      shared_cdb_val = regval[shared_cdb_id];
      if (in_valid && in_ready) exp_q.push_back('{in_dst, regval[in_src1], regval[in_src2]});
      tick();
    end
    in_valid = 1'b0; shared_cdb_transmit = 1'b0;
    ready_regs = 16'hFFFF; out_ready = 1'b1;
    wait_empty(200);

    // Reset while in S_SRC2 with three entries queued
    out_ready = 1'b0;
    ready_regs[12] = 1'b0;
    push(4'd10, 4'd12, 4'd4);
    push(4'd1, 4'd2, 4'd5);
    push(4'd3, 4'd4, 4'd6);
    wait_req_id(4'd12, "reach_src2");
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_requesting", requesting, 0);
    check("midrst_in_ready", in_ready, 1);
    rst = 1'b0;
    ready_regs = 16'hFFFF;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    check("no_stale_output", seen, 0);
    push(4'd13, 4'd14, 4'd15);
    wait_empty(20);

    // Shared CDB broadcast for a source that is not ready
    regval[2] = 8'h33; regval[3] = 8'h44;
    ready_regs[2] = 1'b0;
    s1 = 4'd2; s2 = 4'd3;
`ifdef OPF_CDB_BYPASS_EN
    exp_q.push_back('{4'd5, 8'h77, 8'h44});
`else
    exp_q.push_back('{4'd5, 8'h33, 8'h44});
`endif
    in_src1 = s1; in_src2 = s2; in_dst = 4'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_req_id(4'd2, "reach_src1");
    shared_cdb_transmit = 1'b1; shared_cdb_id = 4'd2; shared_cdb_val = 8'h77;
`ifdef OPF_CDB_BYPASS_EN
    ready_regs[2] = 1'b1;
    #1;
    check("snoop_no_request", requesting, 0);
    tick();
    shared_cdb_transmit = 1'b0;
    check("snoop_advanced", requested_id, 3);
`else
    #1;
    check("no_snoop_request", requesting, 0);
    tick();
    shared_cdb_transmit = 1'b0;
    check("no_snoop_wait", requested_id, 2);
    repeat (3) tick();
    check("no_snoop_no_out", out_valid, 0);
`endif
    ready_regs = 16'hFFFF;
    wait_empty(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter PRF_SIZE, default 16: number of physical registers; register ids are 4 bits wide.
REQ-002 SHALL have parameter DEPTH, default 4: instruction queue entries; must be a power of 2, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): dispatch handshake.
REQ-006 SHALL have ports in_src1, in_src2 and in_dst (input, 4 each): source and destination physical register ids.
REQ-007 SHALL have port ready_regs, input, PRF_SIZE bits: per-register value-valid flags from the register file.
REQ-008 SHALL have ports requesting (output, 1) and requested_id (output, 4): read request to the register file.
REQ-009 SHALL have ports prf_cdb_transmit (input, 1), prf_cdb_id (input, 4) and prf_cdb_val (input, 8): register-file read response, valid in the same cycle as the request.
REQ-010 SHALL have ports shared_cdb_transmit (input, 1), shared_cdb_id (input, 4) and shared_cdb_val (input, 8): shared CDB snoop.
REQ-011 SHALL have ports out_valid (output, 1) and out_ready (input, 1): issue handshake.
REQ-012 SHALL have ports out_dst (output, 4), out_val1 (output, 8) and out_val2 (output, 8): fetched operands.

Function
REQ-013 Queue: circular FIFO of DEPTH entries {src1, src2, dst}.
- Push when in_valid && in_ready.
- in_ready = (count < DEPTH), registered-count based; a same-cycle pop does not raise in_ready.
- Read and write pointers wrap modulo DEPTH.
REQ-014 FSM states and transitions; only the head entry is processed (strictly in order):
- S_IDLE: go to S_SRC1 on the cycle after count becomes nonzero.
- S_SRC1: fetching src1.
- S_SRC2: fetching src2.
- S_OUT: holding the result.
REQ-015 S_SRC1 request and capture:
- requesting = ready_regs[head.src1]; requested_id = head.src1.
- On an edge with requesting && prf_cdb_transmit && prf_cdb_id == head.src1: capture prf_cdb_val into val1.
- After capture, go to S_SRC2, or directly to S_OUT with val2 = same value when head.src2 == head.src1.
REQ-016 S_SRC2: same as REQ-015 for src2/val2, then go to S_OUT.
REQ-017 A response with mismatched prf_cdb_id, or prf_cdb_transmit low, SHALL NOT capture; the state is held and the request is retried.
REQ-018 Source not ready: requesting stays 0 and the state is held indefinitely (no timeout).
REQ-019 Outside S_SRC1/S_SRC2: requesting = 0 and requested_id = 0.
REQ-020 S_OUT:
- out_valid = 1; out_dst, out_val1 and out_val2 stay stable until accepted.
- On out_valid && out_ready: pop the head; go to S_SRC1 if the post-pop count (including any same-cycle push) is nonzero, else S_IDLE.
REQ-021 Minimum latency, all sources ready: push at edge N; S_SRC1 in cycle N+1; S_SRC2 in N+2; out_valid in N+3.
REQ-022 Simultaneous push and pop: both take effect; count is unchanged.

Reset
REQ-023 On rst SHALL set state = S_IDLE, count and both pointers = 0, and clear all captured values.
REQ-024 On rst SHALL drive out_valid = 0, out_dst and both out_val = 0, requesting = 0, requested_id = 0, and in_ready = 1 from the next cycle.
REQ-025 rst SHALL take priority over any same-cycle push, pop or capture; in-flight entries are discarded.

Configuration
REQ-026 Macro OPF_CDB_BYPASS_EN controls CDB snooping.
- Defined: in S_SRC1/S_SRC2, if shared_cdb_transmit && shared_cdb_id == the current src, capture shared_cdb_val and advance as in REQ-015/016, with requesting forced to 0 that cycle. The snoop takes priority over a register-file request.
- Undefined: shared_cdb_* inputs are present but ignored.

Verification
REQ-027 Push {src1=3, src2=5, dst=9} with ready_regs=0xFFFF and the PRF returning 0x11 and 0x22 -> out_valid in the 3rd cycle after the push edge; out_val1=0x11, out_val2=0x22, out_dst=9.
REQ-028 Push {src1=7, src2=7} with val 0x5A -> exactly one request (requested_id=7); out_val1 = out_val2 = 0x5A.
REQ-029 ready_regs[4]=0 for 10 cycles with src1=4 -> requesting stays 0 and out_valid stays 0; set ready_regs[4] -> request and capture in the next edge.
REQ-030 Push 4 entries with out_ready=0 -> in_ready=0 after the 4th push; pops with out_ready=1 drain in order, and pointers wrap correctly across 6 more entries.
REQ-031 rst asserted in S_SRC2 with 3 entries queued -> next cycle out_valid=0, requesting=0, in_ready=1, and no stale output afterwards.
REQ-032 With OPF_CDB_BYPASS_EN, src1=2 and a shared CDB broadcast {id=2, val=0x77} while ready_regs[2]=0 -> val1=0x77 and no request; without the macro -> the block waits for ready_regs[2].
